// File: rtl/mdr_handshake.sv
// Memory data register with a req/ack RAM port: one-word read/write transactions,
// write-data buffer, wait-state counter and optional timeout abort.
module mdr_handshake #(
    parameter int DATA_W     = 16,
    parameter int WAIT_MAX   = 15,
    parameter int TIMEOUT_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] from_bus,
    inout  wire  [DATA_W-1:0] MDR_bus_connect,
    output logic [DATA_W-1:0] REG_OUT_MDR,
    inout  wire  [DATA_W-1:0] MDR_RAM_connect,
    input  logic              MDR_in,
    input  logic              MDR_out,
    input  logic              write_to_MM,
    input  logic              read_from_MM,
    output logic              mem_req,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              timeout
);

    localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_wbuf;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic              r_done;
    logic              r_timeout;
    logic              w_start;
    logic              w_start_wr;
    logic              w_complete;
    logic              w_abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_start_wr  = 1'b0;
        w_complete  = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                // write has priority; a simultaneous read request is dropped
                if (write_to_MM) begin
                    w_state_nxt = WRITE;
                    w_start     = 1'b1;
                    w_start_wr  = 1'b1;
                end else if (read_from_MM) begin
                    w_state_nxt = READ;
                    w_start     = 1'b1;
                end
            end
            READ, WRITE: begin
                if (mem_ack) begin
                    w_state_nxt = IDLE;
                    w_complete  = 1'b1;
                end else if ((TIMEOUT_EN != 0) && (r_wait_cnt == WAIT_LAST)) begin
                    w_state_nxt = IDLE;
                    w_abort     = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        mem_req = (r_state != IDLE);
        busy    = (r_state != IDLE);
        mem_we  = (r_state == WRITE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data     <= '0;
            r_wbuf     <= '0;
            r_wait_cnt <= '0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_done <= w_complete;
            if (MDR_in)
                r_data <= MDR_bus_connect;
            else if (w_complete && (r_state == READ))
                r_data <= MDR_RAM_connect;
            if (w_start_wr)
                r_wbuf <= MDR_in ? from_bus : r_data;
            if (w_start) begin
                r_wait_cnt <= '0;
                r_timeout  <= 1'b0;
            end else if (r_state != IDLE && !mem_ack) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_abort)
                r_timeout <= 1'b1;
        end
    end

    assign MDR_bus_connect = MDR_out ? r_data : 'z;
    assign MDR_RAM_connect = (r_state == WRITE) ? r_wbuf : 'z;
    assign REG_OUT_MDR     = r_data;
    assign done            = r_done;
    assign timeout         = r_timeout;

endmodule

// File: tb/tb_mdr_handshake.sv
// Directed bench for mdr_handshake: reset, read/write handshakes, timeout,
// start arbitration and bus-load collision.
module tb_mdr_handshake;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] from_bus;
    logic        MDR_in, MDR_out, write_to_MM, read_from_MM, mem_ack;
    logic        mem_req, mem_we, busy, done, timeout;
    logic [15:0] REG_OUT_MDR;
    logic        bus_en, ram_en;
    logic [15:0] bus_val, ram_val;
    wire  [15:0] bus_w;
    wire  [15:0] ram_w;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned n_req;

    assign bus_w = bus_en ? bus_val : 'z;
    assign ram_w = ram_en ? ram_val : 'z;

    always #5 clk = ~clk;

    mdr_handshake #(.DATA_W(16), .WAIT_MAX(15), .TIMEOUT_EN(1)) dut (
        .clk            (clk),
        .reset          (reset),
        .from_bus       (from_bus),
        .MDR_bus_connect(bus_w),
        .REG_OUT_MDR    (REG_OUT_MDR),
        .MDR_RAM_connect(ram_w),
        .MDR_in         (MDR_in),
        .MDR_out        (MDR_out),
        .write_to_MM    (write_to_MM),
        .read_from_MM   (read_from_MM),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_ack        (mem_ack),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; from_bus = '0; MDR_in = 0; MDR_out = 0;
        write_to_MM = 0; read_from_MM = 0; mem_ack = 0;
        bus_en = 0; ram_en = 0; bus_val = '0; ram_val = '0;
        #12;
        check("rst_req",  {31'd0, mem_req}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_r",    {16'd0, REG_OUT_MDR}, 32'd0);
        check("rst_to",   {31'd0, timeout}, 32'd0);
        @(negedge clk); reset = 1'b0;
        step();

        // zero-wait read
        ram_en = 1; ram_val = 16'hBEEF; read_from_MM = 1;
        step(); read_from_MM = 0;
        check("rd0_req",  {31'd0, mem_req}, 32'd1);
        check("rd0_we",   {31'd0, mem_we}, 32'd0);
        check("rd0_done_early", {31'd0, done}, 32'd0);
        mem_ack = 1;
        step(); mem_ack = 0;
        check("rd0_req_off", {31'd0, mem_req}, 32'd0);
        check("rd0_r",    {16'd0, REG_OUT_MDR}, 32'h0000BEEF);
        check("rd0_done", {31'd0, done}, 32'd1);
        step();
        check("rd0_done_pulse", {31'd0, done}, 32'd0);
        ram_en = 0;

        // write with bypass and 3 wait states
        bus_en = 1; bus_val = 16'h1111; MDR_in = 1;
        step();
        check("ld_r", {16'd0, REG_OUT_MDR}, 32'h00001111);
        from_bus = 16'hA5A5; write_to_MM = 1;
        step(); write_to_MM = 0; MDR_in = 0; bus_en = 0;
        check("wr_we",  {31'd0, mem_we}, 32'd1);
        check("wr_ram0", {16'd0, ram_w}, 32'h0000A5A5);
        check("wr_r",   {16'd0, REG_OUT_MDR}, 32'h00001111);
        for (int i = 0; i < 3; i++) begin
            step();
            check("wr_wait_req", {31'd0, mem_req}, 32'd1);
            check("wr_wait_ram", {16'd0, ram_w}, 32'h0000A5A5);
        end
        mem_ack = 1;
        step(); mem_ack = 0;
        check("wr_done", {31'd0, done}, 32'd1);
        check("wr_idle", {31'd0, mem_req}, 32'd0);
        check("wr_r_kept", {16'd0, REG_OUT_MDR}, 32'h00001111);

        // timeout after WAIT_MAX cycles
        read_from_MM = 1;
        step(); read_from_MM = 0;
        n_req = 0;
        for (int i = 0; i < 40 && mem_req; i++) begin
            n_req++;
            step();
        end
        check("to_req_cycles", n_req, 32'd15);
        check("to_flag", {31'd0, timeout}, 32'd1);
        check("to_no_done", {31'd0, done}, 32'd0);
        check("to_r_kept", {16'd0, REG_OUT_MDR}, 32'h00001111);
        read_from_MM = 1;
        step(); read_from_MM = 0;
        check("to_clear", {31'd0, timeout}, 32'd0);
        ram_en = 1; ram_val = 16'h1234; mem_ack = 1;
        step(); mem_ack = 0; ram_en = 0;
        check("rd1_r", {16'd0, REG_OUT_MDR}, 32'h00001234);

        // simultaneous starts, then a read request ignored while busy
        read_from_MM = 1; write_to_MM = 1;
        step(); write_to_MM = 0;
        check("both_we", {31'd0, mem_we}, 32'd1);
        check("both_wbuf", {16'd0, ram_w}, 32'h00001234);
        step(); read_from_MM = 0;
        check("ign_we", {31'd0, mem_we}, 32'd1);
        mem_ack = 1;
        step(); mem_ack = 0;
        check("ign_done", {31'd0, done}, 32'd1);
        check("ign_idle", {31'd0, mem_req}, 32'd0);
        step();
        check("ign_no_second", {31'd0, mem_req}, 32'd0);

        // bus load collides with read completion
        ram_en = 1; ram_val = 16'hFFFF; read_from_MM = 1;
        step(); read_from_MM = 0;
        bus_en = 1; bus_val = 16'h0F0F; MDR_in = 1; mem_ack = 1;
        step(); bus_en = 0; MDR_in = 0; mem_ack = 0; ram_en = 0;
        check("col_r", {16'd0, REG_OUT_MDR}, 32'h00000F0F);
        check("col_done", {31'd0, done}, 32'd1);
        MDR_out = 1;
        #1;
        check("bus_drive", {16'd0, bus_w}, 32'h00000F0F);
        MDR_out = 0;

        // asynchronous reset mid-read
        step();
        read_from_MM = 1;
        step(); read_from_MM = 0;
        check("mid_req", {31'd0, mem_req}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_req",  {31'd0, mem_req}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_to",   {31'd0, timeout}, 32'd0);
        check("arst_r",    {16'd0, REG_OUT_MDR}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
